fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the MSP430 pipeline; sits between mem_space and instr_dec.

---
 rtl/fetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: boots from the reset vector, prefetches into a DEPTH-entry queue; 1-cycle ack-to-valid latency (0 with FETCH_BYPASS_EN).
// Backpressure: decoder stalls via instr_ready; fetch requests stop while the queue is full and resume the cycle after a pop frees a slot.
module fetch_queue #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  RST_VEC,
  output logic [SIZE-1:0]  MAB_out,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic [SIZE-1:0]  MDB_in,
  output logic [SIZE-1:0]  instr_out,
  output logic [SIZE-1:0]  instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             flush,
  input  logic [SIZE-1:0]  flush_pc,
  output logic [SIZE-1:0]  fetch_pc,
  output logic [PTR_W:0]   count
);

  typedef enum logic {S_BOOT, S_FETCH} state_t;

  typedef struct packed {
    logic [SIZE-1:0] instr;
    logic [SIZE-1:0] pc;
  } entry_t;

  localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [SIZE-1:0]  PC_STEP  = SIZE'(2);
  localparam logic [SIZE-1:0]  ALIGN    = ~SIZE'(1);

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  entry_t           q [DEPTH];
  entry_t           head;

  logic fetching;
  logic req;
  logic push;
  logic byp;
  logic q_vld;
  logic pop;
  logic wr_en;

  always_comb begin
    fetching = (state == S_FETCH);
    req      = fetching ? ((count != FULL) && !flush) : 1'b1;
    // push already excludes flush, because req is low in a flush cycle
    push     = fetching && req && mem_ack;
    q_vld    = (count != '0) && !(fetching && flush);
`ifdef FETCH_BYPASS_EN
    byp      = push && (count == '0) && instr_ready;
`else
    byp      = 1'b0;
`endif
    pop      = q_vld && instr_ready;
    wr_en    = push && !byp;
    head     = q[rd_ptr];
  end

  always_comb begin
    mem_req     = rst && req;
    MAB_out     = '0;
    instr_valid = rst && (q_vld || byp);
    instr_out   = '0;
    instr_pc    = '0;
    if (rst) begin
      MAB_out   = fetching ? fetch_pc : RST_VEC;
      instr_out = byp ? MDB_in : head.instr;
      instr_pc  = byp ? fetch_pc : head.pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_BOOT;
      fetch_pc <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (!fetching) begin
      if (mem_ack) begin
        fetch_pc <= MDB_in & ALIGN;
        state    <= S_FETCH;
      end
    end else if (flush) begin
      count    <= '0;
      rd_ptr   <= wr_ptr;
      fetch_pc <= flush_pc & ALIGN;
    end else begin
      if (push)
        fetch_pc <= fetch_pc + PC_STEP;
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && !pop)
        count <= count + CNT_ONE;
      else if (!wr_en && pop)
        count <= count - CNT_ONE;
    end
  end

  // Queue storage needs no reset: pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (wr_en)
      q[wr_ptr] <= '{instr: MDB_in, pc: fetch_pc};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every negedge, plus directed literal checks.
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rst_vec;
  logic [15:0] mab;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mdb;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic [15:0] flush_pc;
  logic [15:0] fetch_pc;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'hFFFE) return 16'hC000;
    if (a == 16'h0100) return 16'h4303;
    return a ^ 16'h1234;
  endfunction

  assign mdb = mem_word(mab);

  fetch_queue #(.SIZE(16), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .RST_VEC(rst_vec), .MAB_out(mab), .mem_req(mem_req),
    .mem_ack(mem_ack), .MDB_in(mdb), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .flush(flush),
    .flush_pc(flush_pc), .fetch_pc(fetch_pc), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: booted flag, next fetch address, and a plain queue of entries.
  bit          m_booted;
  logic [15:0] m_pc;
  ent_t        m_q[$];

  always @(negedge clk) begin : compare
    logic e_req, e_byp, e_vld;
    ent_t e_head;
    if (!rst) begin
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_mab", {16'b0, mab}, 32'd0);
      chk("rst_instr", {instr_out, instr_pc}, 32'd0);
      chk("rst_count", {29'b0, count}, 32'd0);
      m_booted = 1'b0;
      m_pc     = 16'h0;
      m_q.delete();
    end else begin
      e_req = m_booted ? (m_q.size() < DEPTH && !flush) : 1'b1;
      e_byp = BYP && m_booted && e_req && mem_ack && m_q.size() == 0 && instr_ready;
      e_vld = e_byp || (m_q.size() != 0 && !(m_booted && flush));
      e_head = e_byp ? '{instr: mem_word(m_pc), pc: m_pc} : (m_q.size() != 0 ? m_q[0] : '0);
      chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
      if (e_req)
        chk("mab", {16'b0, mab}, {16'b0, (m_booted ? m_pc : rst_vec)});
      chk("valid", {31'b0, instr_valid}, {31'b0, e_vld});
      if (e_vld)
        chk("head", {instr_out, instr_pc}, e_head);
      chk("count", {29'b0, count}, m_q.size());
      chk("fetch_pc", {16'b0, fetch_pc}, {16'b0, m_pc});
      if (!m_booted) begin
        if (mem_ack) begin
          m_pc     = mem_word(rst_vec) & 16'hFFFE;
          m_booted = 1'b1;
        end
      end else if (flush) begin
        m_q.delete();
        m_pc = flush_pc & 16'hFFFE;
      end else begin
        if (e_vld && instr_ready && !e_byp)
          void'(m_q.pop_front());
        if (e_req && mem_ack) begin
          if (!e_byp)
            m_q.push_back('{instr: mem_word(m_pc), pc: m_pc});
          m_pc = m_pc + 16'd2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rst_vec = 16'hFFFE; mem_ack = 1'b0; instr_ready = 1'b0;
    flush = 1'b0; flush_pc = 16'h0;
    tick(); tick();
    #2;
    chk("t0_req", {31'b0, mem_req}, 32'd0);
    chk("t0_mab", {16'b0, mab}, 32'd0);

    // Boot from FFFE, vector C000
    tick(); rst = 1'b1;
    #2;
    chk("t1_mab_vec", {16'b0, mab}, 32'h0000FFFE);
    chk("t1_req", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    tick();
    #2;
    chk("t1_mab_c000", {16'b0, mab}, 32'h0000C000);
    tick();
    #2;
    chk("t1_pc_first", {16'b0, instr_pc}, 32'h0000C000);
    chk("t1_instr_first", {16'b0, instr_out}, 32'h0000D234);
    chk("t1_mab_c002", {16'b0, mab}, 32'h0000C002);

    // Fill to DEPTH with decoder stalled
    tick(); tick(); tick();
    #2;
    chk("t2_full", {29'b0, count}, 32'd4);
    chk("t2_req_off", {31'b0, mem_req}, 32'd0);
    instr_ready = 1'b1;
    #1;
    chk("t2_req_off_pop", {31'b0, mem_req}, 32'd0);
    chk("t2_pc0", {16'b0, instr_pc}, 32'h0000C000);
    tick(); mem_ack = 1'b0;
    #2;
    chk("t2_req_back", {31'b0, mem_req}, 32'd1);
    chk("t2_pc1", {16'b0, instr_pc}, 32'h0000C002);
    tick();
    #2;
    chk("t2_pc2", {16'b0, instr_pc}, 32'h0000C004);
    tick();
    #2;
    chk("t2_pc3", {16'b0, instr_pc}, 32'h0000C006);
    tick();
    #2;
    chk("t2_empty", {31'b0, instr_valid}, 32'd0);
    chk("t2_fpc", {16'b0, fetch_pc}, 32'h0000C008);

    // Flush with a coincident ack at count=2
    instr_ready = 1'b0; mem_ack = 1'b1;
    tick(); tick();
    #2;
    chk("t3_cnt2", {29'b0, count}, 32'd2);
    flush = 1'b1; flush_pc = 16'h8001;
    #1;
    chk("t3_valid_flush", {31'b0, instr_valid}, 32'd0);
    tick(); flush = 1'b0; mem_ack = 1'b0;
    #2;
    chk("t3_cnt0", {29'b0, count}, 32'd0);
    chk("t3_valid0", {31'b0, instr_valid}, 32'd0);
    chk("t3_mab", {16'b0, mab}, 32'h00008000);

    // Address wrap at FFFE
    flush = 1'b1; flush_pc = 16'hFFFE;
    tick(); flush = 1'b0; mem_ack = 1'b1;
    #2;
    chk("t4_mab", {16'b0, mab}, 32'h0000FFFE);
    tick(); mem_ack = 1'b0;
    #2;
    chk("t4_fpc_wrap", {16'b0, fetch_pc}, 32'h00000000);
    chk("t4_entry", {instr_out, instr_pc}, 32'hC000FFFE);

    // Bypass case: empty queue, decoder ready, ack data 4303
    flush = 1'b1; flush_pc = 16'h0100;
    tick(); flush = 1'b0; instr_ready = 1'b1; mem_ack = 1'b1;
    #2;
`ifdef FETCH_BYPASS_EN
    chk("t6_byp_valid", {31'b0, instr_valid}, 32'd1);
    chk("t6_byp_instr", {16'b0, instr_out}, 32'h00004303);
`else
    chk("t6_nobyp_valid", {31'b0, instr_valid}, 32'd0);
`endif
    tick(); mem_ack = 1'b0;
    #2;
`ifdef FETCH_BYPASS_EN
    chk("t6_byp_cnt", {29'b0, count}, 32'd0);
`else
    chk("t6_late", {instr_out, instr_pc}, 32'h43030100);
`endif
    tick();

    // Async reset with count=3
    instr_ready = 1'b0; mem_ack = 1'b1;
    tick(); tick(); tick(); mem_ack = 1'b0;
    #2;
    chk("t5_cnt3", {29'b0, count}, 32'd3);
    rst = 1'b0;
    #1;
    chk("t5_req0", {31'b0, mem_req}, 32'd0);
    chk("t5_valid0", {31'b0, instr_valid}, 32'd0);
    tick(); tick(); rst = 1'b1;
    #2;
    chk("t5_mab_vec", {16'b0, mab}, 32'h0000FFFE);

    // Mixed traffic, checked by the model
    for (int i = 0; i < 48; i++) begin
      tick();
      mem_ack     = (i % 3) != 0;
      instr_ready = (i % 4) != 1;
      flush       = (i == 20) || (i == 35);
      flush_pc    = 16'h2001 + 16'(i);
    end
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
